// File: rtl/seven_segment_bcd_mux.sv
// Prescaled BCD up/down counter with a time-multiplexed 7-segment display output.
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seven_segment_bcd_mux #(
  parameter int MAX_COUNT = 10_000_000,
  parameter int DIGITS    = 4,
  parameter int MUX_DIV   = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                count_en,
  input  logic                up_dn,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  output logic [4*DIGITS-1:0] count,
  output logic                carry,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   an
);
  localparam int PW = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam int MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0]       presc_q, presc_d;
  logic [4*DIGITS-1:0] count_q, count_d;
  logic                carry_q, carry_d;
  logic [MW-1:0]       div_q, div_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                tick;
  logic [4*DIGITS-1:0] load_clean, count_up, count_dn;
  logic [DIGITS:0]     up_chain, dn_chain;
  logic [DIGITS-1:0]   blank;
  logic [3:0]          sel_digit;

  assign tick        = (presc_q == PW'(MAX_COUNT - 1));
  assign up_chain[0] = 1'b1;
  assign dn_chain[0] = 1'b1;

  // A digit steps only when every less significant digit is wrapping.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] lv;
      logic [3:0] cur;
      assign lv  = load_value[4*gi +: 4];
      assign cur = count_q[4*gi +: 4];
      assign load_clean[4*gi +: 4] = (lv > 4'd9) ? 4'd0 : lv;
      assign up_chain[gi+1] = up_chain[gi] && (cur == 4'd9);
      assign dn_chain[gi+1] = dn_chain[gi] && (cur == 4'd0);
      assign count_up[4*gi +: 4] = !up_chain[gi] ? cur : ((cur == 4'd9) ? 4'd0 : cur + 4'd1);
      assign count_dn[4*gi +: 4] = !dn_chain[gi] ? cur : ((cur == 4'd0) ? 4'd9 : cur - 4'd1);
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  // upper_zero[i]: digit i and everything above it are zero; digit 0 never blanks.
  logic [DIGITS:1] upper_zero;
  assign upper_zero[DIGITS] = 1'b1;
  assign blank[0] = 1'b0;
  generate
    for (gi = 1; gi < DIGITS; gi++) begin : g_blank
      assign upper_zero[gi] = upper_zero[gi+1] && (count_q[4*gi +: 4] == 4'd0);
      assign blank[gi]      = upper_zero[gi];
    end
  endgenerate
`else
  assign blank = '0;
`endif

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'h3F;
      4'd1:    seg_of = 7'h06;
      4'd2:    seg_of = 7'h5B;
      4'd3:    seg_of = 7'h4F;
      4'd4:    seg_of = 7'h66;
      4'd5:    seg_of = 7'h6D;
      4'd6:    seg_of = 7'h7D;
      4'd7:    seg_of = 7'h07;
      4'd8:    seg_of = 7'h7F;
      4'd9:    seg_of = 7'h6F;
      default: seg_of = 7'h00;
    endcase
  endfunction

  always_comb begin
    presc_d   = presc_q;
    count_d   = count_q;
    carry_d   = 1'b0;
    div_d     = div_q;
    idx_d     = idx_q;
    seg_d     = seg_q;
    an_d      = an_q;
    sel_digit = count_q[4*idx_q +: 4];
    if (ena) begin
      if (load) begin
        presc_d = '0;
        count_d = load_clean;
      end else begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick && count_en) begin
          count_d = up_dn ? count_up : count_dn;
          carry_d = up_dn ? up_chain[DIGITS] : dn_chain[DIGITS];
        end
      end
      if (div_q == MW'(MUX_DIV - 1)) begin
        div_d = '0;
        idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
      an_d  = DIGITS'(1) << idx_q;
      seg_d = blank[idx_q] ? 7'h00 : seg_of(sel_digit);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      div_q   <= '0;
      idx_q   <= '0;
      seg_q   <= 7'h00;
      an_q    <= '0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      carry_q <= carry_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign count = count_q;
  assign carry = carry_q;
  assign seg   = seg_q;
  assign an    = an_q;
endmodule

// File: tb/tb_seven_segment_bcd_mux.sv
// Scoreboard bench for seven_segment_bcd_mux (MAX_COUNT=10, DIGITS=2, MUX_DIV=4).
// Expected outputs come from a decimal-arithmetic cycle model queued per clock.
module tb_seven_segment_bcd_mux;
  localparam int MAX_COUNT = 10;
  localparam int DIGITS    = 2;
  localparam int MUX_DIV   = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LEAD_SEG = 7'h00;
`else
  localparam logic [6:0] LEAD_SEG = 7'h3F;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b1;
  logic       count_en = 1'b0;
  logic       up_dn = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'h00;
  logic [7:0] count;
  logic       carry;
  logic [6:0] seg;
  logic [1:0] an;

  typedef struct packed {
    logic [7:0] count;
    logic       carry;
    logic [6:0] seg;
    logic [1:0] an;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  int         m_cnt, m_presc, m_div, m_idx;
  logic [6:0] m_seg;
  logic [1:0] m_an;
  logic       m_carry;

  always #5 clk = ~clk;

  seven_segment_bcd_mux #(
    .MAX_COUNT(MAX_COUNT), .DIGITS(DIGITS), .MUX_DIV(MUX_DIV)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .count_en(count_en), .up_dn(up_dn),
    .load(load), .load_value(load_value), .count(count), .carry(carry),
    .seg(seg), .an(an)
  );

  function automatic logic [6:0] seg_code(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int sanitize(input logic [7:0] v);
    int lo, hi;
    lo = (v[3:0] > 4'd9) ? 0 : int'(v[3:0]);
    hi = (v[7:4] > 4'd9) ? 0 : int'(v[7:4]);
    return hi * 10 + lo;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_presc = 0; m_div = 0; m_idx = 0;
    m_seg = 7'h00; m_an = 2'b00; m_carry = 1'b0;
    sb_q.delete();
  endtask

  // Advance the model by one clock using the current inputs, queue the
  // expected post-edge outputs, then step to just after the active edge.
  task automatic cycle();
    exp_t e;
    int   digit;
    m_carry = 1'b0;
    if (ena) begin
      digit = (m_idx == 0) ? (m_cnt % 10) : (m_cnt / 10);
      m_seg = seg_code(digit);
`ifdef LEADING_ZERO_BLANK_EN
      if (m_idx == 1 && m_cnt < 10) m_seg = 7'h00;
`endif
      m_an = (m_idx == 0) ? 2'b01 : 2'b10;
      if (load) begin
        m_cnt   = sanitize(load_value);
        m_presc = 0;
      end else begin
        if (m_presc == MAX_COUNT - 1 && count_en) begin
          if (up_dn) begin
            m_carry = (m_cnt == 99);
            m_cnt   = (m_cnt + 1) % 100;
          end else begin
            m_carry = (m_cnt == 0);
            m_cnt   = (m_cnt + 99) % 100;
          end
        end
        m_presc = (m_presc == MAX_COUNT - 1) ? 0 : m_presc + 1;
      end
      if (m_div == MUX_DIV - 1) begin
        m_div = 0;
        m_idx = (m_idx + 1) % DIGITS;
      end else begin
        m_div = m_div + 1;
      end
    end
    e = '{count: to_bcd(m_cnt), carry: m_carry, seg: m_seg, an: m_an};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    exp_t e, got;
    ena = 1'b1; count_en = 1'b0; load = 1'b0; up_dn = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({count, carry, seg, an} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_immediate: got count=%h carry=%b seg=%h an=%b, want all zero", count, carry, seg, an);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    cycle();
    e = sb_q.pop_front(); got = {count, carry, seg, an}; n_checks++;
    if (got !== e) begin
      n_fail++; $display("FAIL reset_first_edge: got %h want %h", got, e);
    end
    n_checks++;
    if (an !== 2'b01 || seg !== 7'h3F) begin
      n_fail++; $display("FAIL first_scan: got an=%b seg=%h, want an=01 seg=3f", an, seg);
    end
    count_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      cycle();
      e = sb_q.pop_front(); got = {count, carry, seg, an}; n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL prerun cyc%0d: got %h want %h", i, got, e);
      end
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({count, carry, seg, an} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_midop: got count=%h carry=%b seg=%h an=%b, want all zero", count, carry, seg, an);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    count_en = 1'b0;
    cycle();
    e = sb_q.pop_front(); got = {count, carry, seg, an}; n_checks++;
    if (got !== e) begin
      n_fail++; $display("FAIL reset_resume: got %h want %h", got, e);
    end
  endtask

  task automatic test_count_up();
    exp_t e, got;
    int   carries = 0;
    bit   saw10 = 0, saw99 = 0;
    do_reset();
    count_en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      cycle();
      e = sb_q.pop_front(); got = {count, carry, seg, an}; n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL count_up cyc%0d: got %h want %h", i, got, e);
      end
      if (carry === 1'b1) carries++;
      if (count === 8'h10) saw10 = 1;
      if (count === 8'h99) saw99 = 1;
    end
    n_checks++;
    if (carries != 1) begin
      n_fail++; $display("FAIL up_carry_count: got %0d carry cycles, want 1", carries);
    end
    n_checks++;
    if (!saw10 || !saw99 || count !== 8'h00) begin
      n_fail++; $display("FAIL up_sequence: saw10=%0d saw99=%0d final=%h, want 1 1 00", saw10, saw99, count);
    end
  endtask

  task automatic test_count_down();
    exp_t e, got;
    count_en = 1'b0; load_value = 8'h00; load = 1'b1;
    cycle();
    load = 1'b0;
    e = sb_q.pop_front(); got = {count, carry, seg, an}; n_checks++;
    if (got !== e) begin
      n_fail++; $display("FAIL down_load: got %h want %h", got, e);
    end
    up_dn = 1'b0; count_en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      e = sb_q.pop_front(); got = {count, carry, seg, an}; n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL count_down cyc%0d: got %h want %h", i, got, e);
      end
      if (i == 10) begin
        n_checks++;
        if (count !== 8'h99 || carry !== 1'b1) begin
          n_fail++; $display("FAIL down_wrap: got count=%h carry=%b, want 99 1", count, carry);
        end
      end
      if (i == 20) begin
        n_checks++;
        if (count !== 8'h98 || carry !== 1'b0) begin
          n_fail++; $display("FAIL down_next: got count=%h carry=%b, want 98 0", count, carry);
        end
      end
    end
  endtask

  task automatic test_load_priority();
    exp_t e, got;
    up_dn = 1'b1; count_en = 1'b1;
    for (int i = 0; i < MAX_COUNT && m_presc != MAX_COUNT - 1; i++) begin
      cycle();
      e = sb_q.pop_front(); got = {count, carry, seg, an}; n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL align cyc%0d: got %h want %h", i, got, e);
      end
    end
    load_value = 8'h47; load = 1'b1;
    cycle();
    load = 1'b0;
    e = sb_q.pop_front(); got = {count, carry, seg, an}; n_checks++;
    if (got !== e || count !== 8'h47 || carry !== 1'b0) begin
      n_fail++; $display("FAIL load_vs_tick: got %h want %h (count 47)", got, e);
    end
    // Reload mid-period: the prescaler restart delays the next step.
    for (int i = 0; i < 5; i++) cycle();
    load = 1'b1;
    cycle();
    load = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      if (i == 9) begin
        n_checks++;
        if (count !== 8'h47) begin
          n_fail++; $display("FAIL presc_clear_hold: got count=%h, want 47", count);
        end
      end
    end
    n_checks++;
    if (count !== 8'h48) begin
      n_fail++; $display("FAIL presc_clear_step: got count=%h, want 48", count);
    end
    for (int i = 0; i < 6; i++) begin
      e = sb_q.pop_front(); got = e;
    end
    while (sb_q.size() > 1) void'(sb_q.pop_front());
    e = sb_q.pop_front(); got = {count, carry, seg, an}; n_checks++;
    if (got !== e) begin
      n_fail++; $display("FAIL reload_model: got %h want %h", got, e);
    end
    count_en = 1'b0; load_value = 8'hA5; load = 1'b1;
    cycle();
    load = 1'b0;
    e = sb_q.pop_front(); got = {count, carry, seg, an}; n_checks++;
    if (got !== e || count !== 8'h05) begin
      n_fail++; $display("FAIL load_invalid: got %h want %h (count 05)", got, e);
    end
  endtask

  task automatic test_scan();
    exp_t       e, got;
    logic [7:0] frz_count;
    logic [6:0] frz_seg;
    logic [1:0] frz_an;
    count_en = 1'b0; load_value = 8'h47; load = 1'b1;
    cycle();
    load = 1'b0;
    e = sb_q.pop_front();
    for (int i = 0; i < 16; i++) begin
      cycle();
      e = sb_q.pop_front(); got = {count, carry, seg, an}; n_checks++;
      if (got !== e || !((an === 2'b01 && seg === 7'h07) || (an === 2'b10 && seg === 7'h66))) begin
        n_fail++; $display("FAIL scan47 cyc%0d: got %h want %h", i, got, e);
      end
    end
    // Mid-scan load: scan position continues, new digits appear next update.
    load_value = 8'h12; load = 1'b1;
    cycle();
    load = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) cycle();
      e = sb_q.pop_front(); got = {count, carry, seg, an}; n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL back_to_back cyc%0d: got %h want %h", i, got, e);
      end
    end
    frz_count = count; frz_seg = seg; frz_an = an;
    ena = 1'b0; count_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      e = sb_q.pop_front(); got = {count, carry, seg, an}; n_checks++;
      if (got !== e || count !== frz_count || seg !== frz_seg || an !== frz_an || carry !== 1'b0) begin
        n_fail++; $display("FAIL ena_freeze cyc%0d: got %h want %h", i, got, e);
      end
    end
    ena = 1'b1; count_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      e = sb_q.pop_front(); got = {count, carry, seg, an}; n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL ena_resume cyc%0d: got %h want %h", i, got, e);
      end
    end
  endtask

  task automatic test_blank();
    exp_t e, got;
    count_en = 1'b0; load_value = 8'h05; load = 1'b1;
    cycle();
    load = 1'b0;
    e = sb_q.pop_front();
    for (int i = 0; i < 8; i++) begin
      cycle();
      e = sb_q.pop_front(); got = {count, carry, seg, an}; n_checks++;
      if (got !== e || !((an === 2'b01 && seg === 7'h6D) || (an === 2'b10 && seg === LEAD_SEG))) begin
        n_fail++; $display("FAIL blank cyc%0d: got an=%b seg=%h, want %h", i, an, seg, e);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_count_up();
    test_count_down();
    test_load_priority();
    test_scan();
    test_blank();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
